uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_tx_sched_if.sv | 37 +++
 rtl/uart_tx_sched.sv | 105 ++++++++++
 tb/tb_uart_tx_sched.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_sched_if.sv
// Requester/UART handshake bundle for uart_tx_sched.
// slave = scheduler side, master = requesters plus UART side.
interface uart_tx_sched_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  req0_valid_in;
  logic [DATA_WIDTH-1:0] req0_data_in;
  logic                  req0_ready_out;
  logic                  req1_valid_in;
  logic [DATA_WIDTH-1:0] req1_data_in;
  logic                  req1_ready_out;
  logic                  uart_tx_en_out;
  logic [DATA_WIDTH-1:0] uart_txdata_out;
  logic                  uart_done_in;
  logic                  grant_id_out;
  logic                  busy_out;
  logic                  timeout_out;
  logic                  clear_timeout_in;

  modport slave (
    input  req0_valid_in, req0_data_in,
    input  req1_valid_in, req1_data_in,
    input  uart_done_in, clear_timeout_in,
    output req0_ready_out, req1_ready_out,
    output uart_tx_en_out, uart_txdata_out,
    output grant_id_out, busy_out, timeout_out
  );

  modport master (
    output req0_valid_in, req0_data_in,
    output req1_valid_in, req1_data_in,
    output uart_done_in, clear_timeout_in,
    input  req0_ready_out, req1_ready_out,
    input  uart_tx_en_out, uart_txdata_out,
    input  grant_id_out, busy_out, timeout_out
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Two-requester round-robin scheduler feeding one UART transmitter,
// with frame timeout and optional inter-frame gap.
module uart_tx_sched #(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 131072,
  parameter int GAP_CYCLES     = 0
) (
  input logic clk_in,
  input logic rst_in,
  uart_tx_sched_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    GAP
  } state_e;

  state_e                state_q;
  logic [CW-1:0]         wcnt_q;
  logic [7:0]            gcnt_q;
  logic                  last_q;
  logic                  grant_q;
  logic                  tx_en_q;
  logic                  tout_q;
  logic [DATA_WIDTH-1:0] data_q;

  logic sel;
  logic rdy0;
  logic rdy1;
  logic xfer;
  logic tout_hit;

  // Tie goes to whoever was not served last.
  assign sel = (bus.req0_valid_in & bus.req1_valid_in)
             ? ~last_q : bus.req1_valid_in;

  assign rdy0 = rst_in & (state_q == IDLE)
              & bus.req0_valid_in & ~sel;
  assign rdy1 = rst_in & (state_q == IDLE)
              & bus.req1_valid_in & sel;
  assign xfer = rdy0 | rdy1;

  assign tout_hit = (wcnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      gcnt_q  <= '0;
      last_q  <= 1'b1;
      grant_q <= 1'b0;
      tx_en_q <= 1'b0;
      tout_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      tx_en_q <= 1'b0;
      if (bus.clear_timeout_in)
        tout_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (xfer) begin
            data_q  <= sel ? bus.req1_data_in
                           : bus.req0_data_in;
            grant_q <= sel;
            last_q  <= sel;
            tx_en_q <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          wcnt_q  <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (wcnt_q != '1)
            wcnt_q <= wcnt_q + 1'b1;
          // Set is written after clear so it wins.
          if (bus.uart_done_in || tout_hit) begin
            if (!bus.uart_done_in)
              tout_q <= 1'b1;
            gcnt_q <= '0;
            state_q <= (GAP_CYCLES > 0) ? GAP : IDLE;
          end
        end
        GAP: begin
          if (gcnt_q == 8'(GAP_CYCLES - 1))
            state_q <= IDLE;
          else
            gcnt_q <= gcnt_q + 1'b1;
        end
      endcase
    end
  end

  assign bus.req0_ready_out  = rdy0;
  assign bus.req1_ready_out  = rdy1;
  assign bus.uart_tx_en_out  = tx_en_q;
  assign bus.uart_txdata_out = data_q;
  assign bus.grant_id_out    = grant_q;
  assign bus.busy_out        = (state_q != IDLE);
  assign bus.timeout_out     = tout_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: one instance with no gap,
// one with a three-cycle gap, both with a 16-cycle timeout.
module tb_uart_tx_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int nchk = 0;
  int nerr = 0;
  logic [8:0] qa[$];
  logic [8:0] qb[$];

  always #5 clk = ~clk;

  uart_tx_sched_if #(.DATA_WIDTH(8)) ia ();
  uart_tx_sched_if #(.DATA_WIDTH(8)) ib ();

  uart_tx_sched #(
    .DATA_WIDTH(8), .TIMEOUT_CYCLES(16), .GAP_CYCLES(0)
  ) dut_a (.clk_in(clk), .rst_in(rst_n), .bus(ia.slave));

  uart_tx_sched #(
    .DATA_WIDTH(8), .TIMEOUT_CYCLES(16), .GAP_CYCLES(3)
  ) dut_b (.clk_in(clk), .rst_in(rst_n), .bus(ib.slave));

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic done_a(input int n);
    repeat (n) tick();
    ia.uart_done_in = 1'b1;
    tick();
    ia.uart_done_in = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [8:0] e;
    if (ia.uart_tx_en_out) begin
      if (qa.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL a_strobe: got unexpected strobe at %0t", $time);
      end else begin
        e = qa.pop_front();
        chk("a_grant", 32'(ia.grant_id_out), 32'(e[8]));
        chk("a_data", 32'(ia.uart_txdata_out), 32'(e[7:0]));
      end
    end
    if (ib.uart_tx_en_out) begin
      if (qb.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL b_strobe: got unexpected strobe at %0t", $time);
      end else begin
        e = qb.pop_front();
        chk("b_grant", 32'(ib.grant_id_out), 32'(e[8]));
        chk("b_data", 32'(ib.uart_txdata_out), 32'(e[7:0]));
      end
    end
  end

  logic       cg [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0] cd [4] = '{8'h11, 8'h22, 8'h11, 8'h22};

  initial begin
    {ia.req0_valid_in, ia.req1_valid_in} = '0;
    {ia.req0_data_in, ia.req1_data_in} = '0;
    {ia.uart_done_in, ia.clear_timeout_in} = '0;
    {ib.req0_valid_in, ib.req1_valid_in} = '0;
    {ib.req0_data_in, ib.req1_data_in} = '0;
    {ib.uart_done_in, ib.clear_timeout_in} = '0;
    tick(); tick();
    ia.req0_valid_in = 1'b1;
    #1;
    chk("rst_ready0", 32'(ia.req0_ready_out), 0);
    chk("rst_busy", 32'(ia.busy_out), 0);
    chk("rst_txen", 32'(ia.uart_tx_en_out), 0);
    chk("rst_data", 32'(ia.uart_txdata_out), 0);
    chk("rst_grant", 32'(ia.grant_id_out), 0);
    chk("rst_tout", 32'(ia.timeout_out), 0);
    ia.req0_valid_in = 1'b0;
    rst_n = 1'b1;
    tick();

    // single request, done ignored during ISSUE
    ia.req0_data_in = 8'h5A; ia.req0_valid_in = 1'b1;
    #1;
    chk("s_ready0", 32'(ia.req0_ready_out), 1);
    chk("s_ready1", 32'(ia.req1_ready_out), 0);
    qa.push_back({1'b0, 8'h5A});
    tick();
    chk("s_issue_txen", 32'(ia.uart_tx_en_out), 1);
    chk("s_issue_ready0", 32'(ia.req0_ready_out), 0);
    chk("s_issue_busy", 32'(ia.busy_out), 1);
    ia.req0_valid_in = 1'b0;
    ia.uart_done_in = 1'b1;
    tick();
    ia.uart_done_in = 1'b0;
    chk("s_wait_busy", 32'(ia.busy_out), 1);
    chk("s_wait_txen", 32'(ia.uart_tx_en_out), 0);
    chk("s_wait_data", 32'(ia.uart_txdata_out), 32'h5A);
    done_a(2);
    chk("s_idle_busy", 32'(ia.busy_out), 0);
    ia.req1_data_in = 8'h33; ia.req1_valid_in = 1'b1;
    #1;
    chk("s_next_ready1", 32'(ia.req1_ready_out), 1);
    qa.push_back({1'b1, 8'h33});
    tick();
    ia.req1_valid_in = 1'b0;
    done_a(2);

    // contention, done 5 cycles after each strobe
    ia.req0_data_in = 8'h11; ia.req1_data_in = 8'h22;
    ia.req0_valid_in = 1'b1; ia.req1_valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("c_ready0", 32'(ia.req0_ready_out), 32'(!cg[i]));
      chk("c_ready1", 32'(ia.req1_ready_out), 32'(cg[i]));
      qa.push_back({cg[i], cd[i]});
      tick();
      if (i == 3) begin
        ia.req0_valid_in = 1'b0; ia.req1_valid_in = 1'b0;
      end
      done_a(5);
    end

    // timeout, with clear held in the set cycle
    ia.req0_data_in = 8'h77; ia.req0_valid_in = 1'b1;
    qa.push_back({1'b0, 8'h77});
    tick();
    ia.req0_valid_in = 1'b0;
    tick();
    repeat (14) tick();
    ia.clear_timeout_in = 1'b1;
    tick();
    chk("t_busy_last", 32'(ia.busy_out), 1);
    chk("t_not_yet", 32'(ia.timeout_out), 0);
    tick();
    ia.clear_timeout_in = 1'b0;
    chk("t_set", 32'(ia.timeout_out), 1);
    chk("t_idle", 32'(ia.busy_out), 0);
    ia.req1_data_in = 8'h44; ia.req1_valid_in = 1'b1;
    #1;
    chk("t_ready1", 32'(ia.req1_ready_out), 1);
    qa.push_back({1'b1, 8'h44});
    tick();
    ia.req1_valid_in = 1'b0;
    done_a(3);
    chk("t_sticky", 32'(ia.timeout_out), 1);
    ia.clear_timeout_in = 1'b1;
    tick();
    ia.clear_timeout_in = 1'b0;
    chk("t_cleared", 32'(ia.timeout_out), 0);

    // done on the last allowed WAIT cycle
    ia.req0_data_in = 8'h66; ia.req0_valid_in = 1'b1;
    qa.push_back({1'b0, 8'h66});
    tick();
    ia.req0_valid_in = 1'b0;
    done_a(16);
    chk("b_tout", 32'(ia.timeout_out), 0);
    chk("b_idle", 32'(ia.busy_out), 0);

    // reset mid-WAIT
    ia.req0_data_in = 8'hA5; ia.req0_valid_in = 1'b1;
    qa.push_back({1'b0, 8'hA5});
    tick();
    ia.req0_valid_in = 1'b0;
    tick(); tick();
    chk("r_inflight", 32'(ia.uart_txdata_out), 32'hA5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("r_data", 32'(ia.uart_txdata_out), 0);
    chk("r_grant", 32'(ia.grant_id_out), 0);
    chk("r_busy", 32'(ia.busy_out), 0);
    chk("r_txen", 32'(ia.uart_tx_en_out), 0);
    ia.uart_done_in = 1'b1;
    tick();
    ia.uart_done_in = 1'b0;
    chk("r_late_busy", 32'(ia.busy_out), 0);
    chk("r_late_tout", 32'(ia.timeout_out), 0);
    ia.req0_data_in = 8'h11; ia.req1_data_in = 8'h22;
    ia.req0_valid_in = 1'b1; ia.req1_valid_in = 1'b1;
    #1;
    chk("r_tie_ready0", 32'(ia.req0_ready_out), 1);
    chk("r_tie_ready1", 32'(ia.req1_ready_out), 0);
    qa.push_back({1'b0, 8'h11});
    tick();
    ia.req0_valid_in = 1'b0; ia.req1_valid_in = 1'b0;
    done_a(2);

    // three-cycle gap on the second instance
    ib.req0_data_in = 8'hC3; ib.req0_valid_in = 1'b1;
    #1;
    chk("g_ready0", 32'(ib.req0_ready_out), 1);
    qb.push_back({1'b0, 8'hC3});
    tick();
    ib.req0_valid_in = 1'b0;
    tick(); tick();
    ib.uart_done_in = 1'b1;
    tick();
    ib.uart_done_in = 1'b0;
    ib.req0_data_in = 8'h5C; ib.req1_data_in = 8'h3C;
    ib.req0_valid_in = 1'b1; ib.req1_valid_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("g_gap_ready0", 32'(ib.req0_ready_out), 0);
      chk("g_gap_ready1", 32'(ib.req1_ready_out), 0);
      chk("g_gap_busy", 32'(ib.busy_out), 1);
      tick();
    end
    #1;
    chk("g_after_ready1", 32'(ib.req1_ready_out), 1);
    chk("g_after_ready0", 32'(ib.req0_ready_out), 0);
    qb.push_back({1'b1, 8'h3C});
    tick();
    ib.req0_valid_in = 1'b0; ib.req1_valid_in = 1'b0;
    tick(); tick();
    ib.uart_done_in = 1'b1;
    tick();
    ib.uart_done_in = 1'b0;
    repeat (4) tick();
    chk("g_idle", 32'(ib.busy_out), 0);

    repeat (2) tick();
    chk("qa_drained", 32'(qa.size()), 0);
    chk("qb_drained", 32'(qb.size()), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
